inst_fetcher: RTL
=================

INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL provide: clk  input  1  single clock, all state updates on posedge.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: rdy  input  1  global enable; when 0 every register holds.
REQ-004 SHALL provide: in_rob_xbp  input  1  mispredict flush; in_rob_newpc  input  32  redirect PC.
REQ-005 SHALL provide: in_iq_full  input  1  downstream instruction queue full (stall).
REQ-006 SHALL provide: out_mem_flag  output  1  one-cycle fetch request pulse to memory controller; out_mem_addr  output  32  fetch address.
REQ-007 SHALL provide: in_mem_flag  input  1  fetch data valid pulse; in_mem_data  input  32  fetched word, little-endian assembled.
REQ-008 SHALL provide: out_inst_flag  output  1  instruction valid pulse; out_inst  output  32; out_pc  output  32.

Function
REQ-009 SHALL hold a direct-mapped I-cache: 64 entries, index pc[7:2], tag pc[17:8], per-entry valid bit, 32-bit data.
REQ-010 SHALL implement two states: IDLE and MISS_WAIT.
REQ-011 IDLE, no stall, hit at pc: SHALL, next edge, drive out_inst_flag=1, out_inst=cached word, out_pc=pc, and set pc<=pc+4 (1-cycle latency, one instruction per cycle).
REQ-012 IDLE, no stall, miss: SHALL pulse out_mem_flag for exactly one cycle, set out_mem_addr<=pc, enter MISS_WAIT, with out_inst_flag=0.
REQ-013 out_mem_addr SHALL remain stable from the request until in_mem_flag is sampled, because the memory controller samples the address when it begins service, not at the request.
REQ-014 MISS_WAIT on in_mem_flag=1: SHALL write data/tag/valid at the out_mem_addr index, return to IDLE, and, when not stalled, issue in_mem_data with out_pc=pc on the same edge and set pc<=pc+4.
REQ-015 in_mem_flag while stalled: SHALL fill the cache and return to IDLE, without issuing and without advancing pc; the next unstalled cycle hits.
REQ-016 in_iq_full=1 in IDLE: SHALL NOT issue, request, or advance pc; out_inst_flag=0.
REQ-017 in_rob_xbp=1 (highest priority after rst): SHALL set pc<=in_rob_newpc, force out_inst_flag=0 and out_mem_flag=0, and enter IDLE, abandoning any outstanding miss.
REQ-018 in_mem_flag together with in_rob_xbp: SHALL still fill the cache (data matches out_mem_addr) and SHALL NOT issue.
REQ-019 in_mem_flag in IDLE (stale response after flush): SHALL be ignored, with no fill.
REQ-020 pc+4 SHALL wrap modulo 2^32; pc[1:0] SHALL be treated as 0.
REQ-021 out_inst_flag and out_mem_flag SHALL be single-cycle pulses, deasserted by default every enabled cycle.

Reset
REQ-022 rst SHALL clear pc=0, state=IDLE, all valid bits=0, out_mem_flag=0, out_mem_addr=0, out_inst_flag=0, out_inst=0, out_pc=0.
REQ-023 rst during MISS_WAIT SHALL abandon the miss; a later in_mem_flag SHALL be ignored per REQ-019.
REQ-024 rst SHALL take effect regardless of rdy.

Structure
REQ-025 SHALL take DATA_TYPE, TRUE/FALSE, ZERO_WORD and new ICACHE_SIZE/ICACHE_INDEX/ICACHE_TAG ranges from the shared definition header.
REQ-026 SHALL factor the cache arrays and hit comparison into one sub-module, icache (read port: combinational hit/data; write port: fill on posedge).
REQ-027 The FSM, pc register and handshakes SHALL reside in inst_fetcher.

Verification
REQ-028 After reset, pc=0 misses -> one out_mem_flag pulse with out_mem_addr=0x0; return in_mem_data=0x00500093 -> out_inst=0x00500093, out_pc=0, then a request for 0x4.
REQ-029 Refetch 0x0 after fill (via xbp newpc=0) -> hit, out_inst_flag on the edge after xbp+1, no out_mem_flag.
REQ-030 in_iq_full=1 for 3 cycles on a hit path -> no issue, pc constant; on release, issue resumes at the same pc.
REQ-031 xbp to 0x100 while MISS_WAIT at 0x8 -> no issue of 0x8; the next request has out_mem_addr=0x100; a late in_mem_flag in IDLE produces no fill.
REQ-032 Alias 0x0 and 0x100 (same index, different tag) -> second access misses and replaces; returning to 0x0 misses again.
REQ-033 rdy=0 for 2 cycles mid-MISS_WAIT -> all outputs hold; completion proceeds normally after rdy=1.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: word type, boolean constants,
// I-cache geometry and the fetch FSM state encoding.
package inst_fetcher_pkg;

  localparam int DATA_W = 32;
  typedef logic [DATA_W-1:0] DATA_TYPE;

  localparam logic     TRUE      = 1'b1;
  localparam logic     FALSE     = 1'b0;
  localparam DATA_TYPE ZERO_WORD = '0;

  // Direct-mapped: 64 words, index from pc[7:2], tag from pc[17:8].
  localparam int ICACHE_SIZE     = 64;
  localparam int ICACHE_INDEX_HI = 7;
  localparam int ICACHE_INDEX_LO = 2;
  localparam int ICACHE_TAG_HI   = 17;
  localparam int ICACHE_TAG_LO   = 8;
  localparam int ICACHE_INDEX_W  = ICACHE_INDEX_HI - ICACHE_INDEX_LO + 1;
  localparam int ICACHE_TAG_W    = ICACHE_TAG_HI - ICACHE_TAG_LO + 1;

  typedef logic [ICACHE_INDEX_W-1:0] icache_index_t;
  typedef logic [ICACHE_TAG_W-1:0]   icache_tag_t;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_MISS_WAIT = 1'b1
  } fetch_state_e;

  // Word-aligned successor; wraps modulo 2^32 and ignores pc[1:0].
  function automatic DATA_TYPE pc_plus4(input DATA_TYPE pc);
    return (pc & ~DATA_TYPE'(3)) + DATA_TYPE'(4);
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Bundle of flush, memory-request and instruction-issue signals between the
// fetcher (master) and its environment (slave).
interface inst_fetcher_if import inst_fetcher_pkg::*; ();

  // Handshakes: every *_flag is a one-cycle valid pulse with no ready return.
  // The only backpressure is in_iq_full, which stalls issue and new requests;
  // out_mem_addr stays stable from out_mem_flag until in_mem_flag returns.
  logic     in_rob_xbp;
  DATA_TYPE in_rob_newpc;
  logic     in_iq_full;
  logic     out_mem_flag;
  DATA_TYPE out_mem_addr;
  logic     in_mem_flag;
  DATA_TYPE in_mem_data;
  logic     out_inst_flag;
  DATA_TYPE out_inst;
  DATA_TYPE out_pc;

  modport master (
    input  in_rob_xbp, in_rob_newpc, in_iq_full, in_mem_flag, in_mem_data,
    output out_mem_flag, out_mem_addr, out_inst_flag, out_inst, out_pc
  );

  modport slave (
    output in_rob_xbp, in_rob_newpc, in_iq_full, in_mem_flag, in_mem_data,
    input  out_mem_flag, out_mem_addr, out_inst_flag, out_inst, out_pc
  );

endinterface

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped instruction cache: combinational hit/data read port and a
// posedge fill port. Only the valid bits are reset.
module inst_fetcher_icache import inst_fetcher_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  icache_index_t rd_index_i,
  input  icache_tag_t   rd_tag_i,
  output logic          rd_hit_o,
  output DATA_TYPE      rd_data_o,
  input  logic          wr_en_i,
  input  icache_index_t wr_index_i,
  input  icache_tag_t   wr_tag_i,
  input  DATA_TYPE      wr_data_i
);

  logic [ICACHE_SIZE-1:0] valid_q;
  icache_tag_t            tag_q  [ICACHE_SIZE];
  DATA_TYPE               data_q [ICACHE_SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= TRUE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_index_i];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: pc register, IDLE/MISS_WAIT FSM, memory-request and
// instruction-issue handshakes around a direct-mapped I-cache.
module inst_fetcher import inst_fetcher_pkg::*; (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  inst_fetcher_if.master bus,
  output fetch_state_e   dbg_state_o
);

  fetch_state_e state_q, state_d;
  DATA_TYPE     pc_q, pc_d;
  logic         mem_flag_q, mem_flag_d;
  DATA_TYPE     mem_addr_q, mem_addr_d;
  logic         inst_flag_q, inst_flag_d;
  DATA_TYPE     inst_q, inst_d;
  DATA_TYPE     out_pc_q, out_pc_d;

  logic         hit;
  DATA_TYPE     hit_data;
  logic         fill_en;

  // The fill lands at the requested address even if a flush arrives with it.
  assign fill_en = rdy && !rst && (state_q == ST_MISS_WAIT) && bus.in_mem_flag;

  inst_fetcher_icache u_icache (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (pc_q[ICACHE_INDEX_HI:ICACHE_INDEX_LO]),
    .rd_tag_i   (pc_q[ICACHE_TAG_HI:ICACHE_TAG_LO]),
    .rd_hit_o   (hit),
    .rd_data_o  (hit_data),
    .wr_en_i    (fill_en),
    .wr_index_i (mem_addr_q[ICACHE_INDEX_HI:ICACHE_INDEX_LO]),
    .wr_tag_i   (mem_addr_q[ICACHE_TAG_HI:ICACHE_TAG_LO]),
    .wr_data_i  (bus.in_mem_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= ZERO_WORD;
      mem_flag_q  <= FALSE;
      mem_addr_q  <= ZERO_WORD;
      inst_flag_q <= FALSE;
      inst_q      <= ZERO_WORD;
      out_pc_q    <= ZERO_WORD;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_flag_q  <= mem_flag_d;
      mem_addr_q  <= mem_addr_d;
      inst_flag_q <= inst_flag_d;
      inst_q      <= inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_flag_d  = FALSE;
    mem_addr_d  = mem_addr_q;
    inst_flag_d = FALSE;
    inst_d      = inst_q;
    out_pc_d    = out_pc_q;

    if (bus.in_rob_xbp) begin
      pc_d    = bus.in_rob_newpc & ~DATA_TYPE'(3);
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.in_iq_full) begin
            if (hit) begin
              inst_flag_d = TRUE;
              inst_d      = hit_data;
              out_pc_d    = pc_q;
              pc_d        = pc_plus4(pc_q);
            end else begin
              mem_flag_d = TRUE;
              mem_addr_d = pc_q;
              state_d    = ST_MISS_WAIT;
            end
          end
        end
        ST_MISS_WAIT: begin
          // A stalled fill returns to IDLE without issue; the next cycle hits.
          if (bus.in_mem_flag) begin
            state_d = ST_IDLE;
            if (!bus.in_iq_full) begin
              inst_flag_d = TRUE;
              inst_d      = bus.in_mem_data;
              out_pc_d    = pc_q;
              pc_d        = pc_plus4(pc_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.out_mem_flag  = mem_flag_q;
  assign bus.out_mem_addr  = mem_addr_q;
  assign bus.out_inst_flag = inst_flag_q;
  assign bus.out_inst      = inst_q;
  assign bus.out_pc        = out_pc_q;
  assign dbg_state_o       = state_q;

endmodule
